// File: rtl/bram_access_arbiter.sv
// Arbiter for one single-port frame BRAM: display reads beat the page-clear
// sweep, which beats single-word draw writes. BRAM pins are a combinational mux.
module bram_access_arbiter #(
   parameter int N     = 13,
   parameter int W     = 16,
   parameter int DEPTH = 6144
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         disp_req,
   input  logic [N-1:0] disp_addr,
   output logic [W-1:0] disp_data,
   output logic         disp_valid,
   input  logic         wr_req,
   input  logic [N-1:0] wr_addr,
   input  logic [W-1:0] wr_data,
   output logic         wr_gnt,
   input  logic         clear_start,
   input  logic [W-1:0] clear_color,
   output logic         clear_busy,
   output logic         clear_done,
   output logic [N-1:0] bram_addr,
   output logic         bram_rw,
   output logic [W-1:0] bram_din,
   input  logic [W-1:0] bram_dout
);

   localparam logic [N-1:0] DEPTH_N = N'(DEPTH);
   localparam logic [N-1:0] LAST    = N'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t       state, state_nxt;
   logic [N-1:0] clr_cnt, clr_cnt_nxt;
   logic [W-1:0] clr_color_q;
   logic         latch_color;
   logic         done_nxt;
   logic         rw_c;
   logic         gnt_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         clr_cnt     <= '0;
         clr_color_q <= '0;
         disp_valid  <= 1'b0;
         clear_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         clr_cnt    <= clr_cnt_nxt;
         disp_valid <= disp_req;
         clear_done <= done_nxt;
         if (latch_color) clr_color_q <= clear_color;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      latch_color = 1'b0;
      done_nxt    = 1'b0;
      bram_addr   = disp_addr;
      bram_din    = wr_data;
      rw_c        = 1'b0;
      gnt_c       = 1'b0;
      case (state)
         IDLE: begin
            if (clear_start) begin
               latch_color = 1'b1;
               clr_cnt_nxt = '0;
               state_nxt   = CLEAR;
            end else if (wr_req && !disp_req) begin
               // out-of-range draws are acknowledged but never reach the BRAM
               gnt_c     = 1'b1;
               bram_addr = wr_addr;
               rw_c      = (wr_addr < DEPTH_N);
            end
         end
         CLEAR: begin
            if (!disp_req) begin
               bram_addr = clr_cnt;
               bram_din  = clr_color_q;
               rw_c      = 1'b1;
               if (clr_cnt == LAST) begin
                  done_nxt    = 1'b1;
                  clr_cnt_nxt = '0;
                  state_nxt   = IDLE;
               end else begin
                  clr_cnt_nxt = clr_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // keep the BRAM write-enable and grant quiet while reset is held
   assign bram_rw    = rw_c & rst_n;
   assign wr_gnt     = gnt_c & rst_n;
   assign disp_data  = bram_dout;
   assign clear_busy = (state == CLEAR);

endmodule
